// File: rtl/vid_timing_pkg.sv
// Shared constants for the fvht video timing interface.
// Bit positions, idle pattern and 1080p raster defaults.
package vid_timing_pkg;

    localparam int FVHT_F = 3;
    localparam int FVHT_V = 2;
    localparam int FVHT_H = 1;
    localparam int FVHT_T = 0;

    localparam logic [3:0] FVHT_IDLE = 4'b0110;

    localparam int H_ACTIVE_1080 = 1920;
    localparam int H_BLANK_1080  = 280;
    localparam int V_ACTIVE_1080 = 1080;
    localparam int V_BLANK_1080  = 45;

endpackage

// File: rtl/vid_wrap_cnt.sv
// Modulo-N counter with synchronous clear and terminal flag.
// last_o flags the final count so a cascaded counter can step.
module vid_wrap_cnt #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last_o = (cnt_q == W'(N - 1));
    assign cnt_o  = cnt_q;

    // Clear wins over count; count wraps to zero after N-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing source: F/V/H/T flags and active-pixel coordinates.
// Blanking precedes active on both axes; every output is registered.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080,
    parameter int H_BLANK  = H_BLANK_1080,
    parameter int V_ACTIVE = V_ACTIVE_1080,
    parameter int V_BLANK  = V_BLANK_1080,
    parameter int HW       = 12,
    parameter int VW       = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cen_i,
    input  logic          run_i,
    output logic [3:0]    fvht_o,
    output logic [HW-1:0] pix_x_o,
    output logic [VW-1:0] pix_y_o,
    output logic          active_o,
    output logic          sof_o
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;

    localparam logic [HW-1:0] HB = HW'(H_BLANK);
    localparam logic [VW-1:0] VB = VW'(V_BLANK);

    if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 || V_BLANK < 1) begin : g_bad_size
        $error("vid_timing_gen: active and blank sizes must be >= 1");
    end

    if ((64'd1 << HW) < 64'(H_TOTAL)) begin : g_bad_hw
        $error("vid_timing_gen: HW too narrow for H_TOTAL");
    end

    if ((64'd1 << VW) < 64'(V_TOTAL)) begin : g_bad_vw
        $error("vid_timing_gen: VW too narrow for V_TOTAL");
    end

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          h_last;
    logic          v_last_unused;
    logic          step;
    logic          clr;

    assign step = cen_i & run_i;
    assign clr  = cen_i & ~run_i;

    vid_wrap_cnt #(
        .N (H_TOTAL),
        .W (HW)
    ) u_hcnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (step),
        .clr_i  (clr),
        .cnt_o  (hc),
        .last_o (h_last)
    );

    vid_wrap_cnt #(
        .N (V_TOTAL),
        .W (VW)
    ) u_vcnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (step & h_last),
        .clr_i  (clr),
        .cnt_o  (vc),
        .last_o (v_last_unused)
    );

    logic [3:0]    fvht_q,   fvht_d;
    logic [HW-1:0] pix_x_q,  pix_x_d;
    logic [VW-1:0] pix_y_q,  pix_y_d;
    logic          active_q, active_d;
    logic          sof_q,    sof_d;

    logic h_blank;
    logic v_blank;
    logic act;

    assign h_blank = (hc < HB);
    assign v_blank = (vc < VB);
    assign act     = ~h_blank & ~v_blank;

    // Decode current position on a running cen cycle, idle when stopped, else hold.
    always_comb begin
        fvht_d   = fvht_q;
        pix_x_d  = pix_x_q;
        pix_y_d  = pix_y_q;
        active_d = active_q;
        sof_d    = sof_q;
        if (cen_i) begin
            if (run_i) begin
                fvht_d         = '0;
                fvht_d[FVHT_F] = 1'b0;
                fvht_d[FVHT_V] = v_blank;
                fvht_d[FVHT_H] = h_blank;
                fvht_d[FVHT_T] = (hc == '0) || (hc == HB);
                pix_x_d        = act ? hc - HB : '0;
                pix_y_d        = act ? vc - VB : '0;
                active_d       = act;
                sof_d          = (hc == '0) && (vc == '0);
            end else begin
                fvht_d   = FVHT_IDLE;
                pix_x_d  = '0;
                pix_y_d  = '0;
                active_d = 1'b0;
                sof_d    = 1'b0;
            end
        end
    end

    // Output registers; reset forces the idle pattern.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fvht_q   <= FVHT_IDLE;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            active_q <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            fvht_q   <= fvht_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
            active_q <= active_d;
            sof_q    <= sof_d;
        end
    end

    assign fvht_o   = fvht_q;
    assign pix_x_o  = pix_x_q;
    assign pix_y_o  = pix_y_q;
    assign active_o = active_q;
    assign sof_o    = sof_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen on a 12x6 raster.
// Expected samples come from an independent position model.
module tb_vid_timing_gen;
    import vid_timing_pkg::*;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VB = 2;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;

    localparam logic [12:0] IDLE = {FVHT_IDLE, 9'd0};

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cen_i = 1'b1;
    logic       run_i = 1'b0;
    logic [3:0] fvht_o;
    logic [3:0] pix_x_o;
    logic [2:0] pix_y_o;
    logic       active_o;
    logic       sof_o;

    vid_timing_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .HW       (4),
        .VW       (3)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cen_i    (cen_i),
        .run_i    (run_i),
        .fvht_o   (fvht_o),
        .pix_x_o  (pix_x_o),
        .pix_y_o  (pix_y_o),
        .active_o (active_o),
        .sof_o    (sof_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int mh = 0;
    int mv = 0;
    logic [12:0] held = IDLE;
    logic [12:0] obs;

    assign obs = {fvht_o, pix_x_o, pix_y_o, active_o, sof_o};

    function automatic logic [12:0] dec(input int h, input int v);
        logic hb, vb, act, t, sof;
        int px, py;
        logic [3:0] pxl;
        logic [2:0] pyl;
        hb  = (h < HB);
        vb  = (v < VB);
        act = !hb && !vb;
        t   = (h == 0) || (h == HB);
        sof = (h == 0) && (v == 0);
        px  = act ? h - HB : 0;
        py  = act ? v - VB : 0;
        pxl = px[3:0];
        pyl = py[2:0];
        return {1'b0, vb, hb, t, pxl, pyl, act, sof};
    endfunction

    task automatic check(input string tag, input logic [12:0] e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic adv();
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    // One running cen sample checked against the model.
    task automatic sample(input string tag);
        tick();
        held = dec(mh, mv);
        check(tag, held);
        adv();
    endtask

    initial begin
        int n;
        int sofs;
        int acts;
        int hfalls;
        int vrises;
        logic ph, pv;

        // 1: reset held with clock and cen running, then released idle
        rst_i = 1'b1;
        cen_i = 1'b1;
        run_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", IDLE);
        end
        rst_i = 1'b0;
        tick();
        check("idle_after_reset", IDLE);
        tick();
        check("idle_run_low", IDLE);

        // 2: one full frame with cen always high
        run_i = 1'b1;
        sofs  = 0;
        for (int i = 0; i < HT * VT; i++) begin
            sample("frame_full_cen");
            if (sof_o) sofs++;
        end
        check_int("frame_sof_count", sofs, 1);
        check_int("frame_end_pos", mh * 100 + mv, 0);

        // 3: 30% cen duty, gaps invisible in the sample stream
        n = 0;
        for (int i = 0; i < 2000 && n < HT * VT; i++) begin
            logic c;
            c = ($urandom_range(0, 9) < 3);
            cen_i = c;
            tick();
            if (c) begin
                held = dec(mh, mv);
                check("cen_sample", held);
                adv();
                n++;
            end else begin
                check("cen_hold", held);
            end
        end
        check_int("cen_sample_count", n, HT * VT);
        cen_i = 1'b1;

        // 4: three frames, wrap and pulse counts
        sofs   = 0;
        acts   = 0;
        hfalls = 0;
        vrises = 0;
        ph = held[10];
        pv = held[11];
        for (int i = 0; i < 3 * HT * VT; i++) begin
            sample("three_frames");
            if (sof_o) sofs++;
            if (active_o) acts++;
            if (ph && !fvht_o[FVHT_H]) hfalls++;
            if (!pv && fvht_o[FVHT_V]) begin
                if (vrises > 0) check_int("h_falls_per_frame", hfalls, VT);
                vrises++;
                hfalls = 0;
            end
            ph = fvht_o[FVHT_H];
            pv = fvht_o[FVHT_V];
        end
        check_int("sof_pulses_3f", sofs, 3);
        check_int("active_count_3f", acts, 3 * HA * VA);
        check_int("v_rises_3f", vrises, 3);

        // 5: drop run mid-frame at (6,3), raise 5 cycles later
        for (int i = 0; i < 3 * HT + 6; i++) sample("pre_abort");
        check_int("abort_pos", mh * 100 + mv, 603);
        run_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("run_low_idle", IDLE);
        end
        mh = 0;
        mv = 0;
        run_i = 1'b1;
        sample("restart_first");
        check_int("restart_sof", int'(sof_o), 1);
        check_int("restart_t", int'(fvht_o[FVHT_T]), 1);

        // 6: async reset between edges at hc=9
        for (int i = 0; i < 8; i++) sample("pre_reset");
        check_int("reset_pos", mh, 9);
        #3;
        rst_i = 1'b1;
        #1;
        check("async_reset_now", IDLE);
        #2;
        rst_i = 1'b0;
        check("async_reset_rel", IDLE);
        mh = 0;
        mv = 0;
        for (int i = 0; i < HT + 2; i++) sample("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
